decode_unit: RTL and testbench
==============================

// Module: decode_unit
// PURPOSE
//  ID stage of the RISCAT 5-stage pipeline. Consumes the IF_ID register from the fetch stage.
//  Reads the integrated 32x32 register file and decodes the RV32I immediate.
//  Registers the ID_EX struct for the execute stage.
//  Detects load-use hazards (asserts stall so fetch holds) and squashes on flush.
// PARAMETERS
//  XLEN   32  datapath / register width
//  NREGS  32  architectural registers; x0 hardwired to zero
//  PC_W   16  program-counter width, matches IF_ID.pc
// PORTS
//  clk        in   1     pipeline clock
//  reset_n    in   1     asynchronous active-low reset
//  if_id_reg  in   IF_ID {pc[15:0], fetched_inst[31:0]} from fetch
//  flush      in   1     taken branch/jump resolved in EX; squash instruction in ID
//  wb_en      in   1     writeback enable from WB stage
//  wb_rd      in   5     writeback destination index
//  wb_data    in   XLEN  writeback value
//  stall      out  1     load-use hazard; fetch must hold IF_ID and PC this cycle
//  id_ex_reg  out  ID_EX {valid, pc[15:0], rs1_val[31:0], rs2_val[31:0], imm[31:0],
//                        rs1[4:0], rs2[4:0], rd[4:0], opcode[6:0], funct3[2:0], funct7b5}
// BEHAVIOUR
//  - Reset (async, immediate, also mid-operation):
//    - id_ex_reg = all zero (valid=0).
//    - All registers cleared to 0.
//    - stall therefore reads 0.
//  - Latency: one cycle. id_ex_reg updates on posedge clk from the current if_id_reg.
//  - Regfile write at posedge when wb_en && wb_rd!=0. Writes to x0 are ignored; x0 reads as 0.
//  - Write-through bypass: if wb_en && wb_rd!=0 && wb_rd==rsN in the same cycle,
//    rsN_val takes wb_data, not the stale array value.
//  - Field extraction:
//    - rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7b5=[30], opcode=[6:0].
//  - Immediate, sign-extended to XLEN; selected by opcode:
//    - I: 0010011, 0000011, 1100111 -> {{20{i[31]}}, i[31:20]}
//    - S: 0100011                   -> {{20{i[31]}}, i[31:25], i[11:7]}
//    - B: 1100011                   -> {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}
//    - U: 0110111, 0010111          -> {i[31:12], 12'b0}
//    - J: 1101111                   -> {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}
//    - R-type and unknown opcodes   -> imm = 0
//  - Operand use:
//    - rs1 is used by every opcode except U and J.
//    - rs2 is used by R (0110011), S and B only.
//  - Bubble:
//    - fetched_inst==32'h0 is a bubble: valid=0, all other fields 0.
//    - A bubble never raises stall.
//  - Load-use hazard (combinational):
//    - stall = id_ex_reg.valid && id_ex_reg.opcode==0000011 && id_ex_reg.rd!=0
//      && ((rs1 used && rs1==id_ex_reg.rd) || (rs2 used && rs2==id_ex_reg.rd)).
//    - When stall=1, the next edge loads a bubble into id_ex_reg.
//    - IF_ID is held by fetch, so the instruction re-decodes next cycle with stall=0.
//    - A stall lasts exactly one cycle.
//  - Flush:
//    - flush=1 at an edge loads a bubble into id_ex_reg.
//    - flush has priority over stall, and stall is forced to 0 while flush=1.
//  - pc is passed through unchanged. No arithmetic on it here.
// TESTING
//  - Reset: drive reset_n=0 mid-stream -> id_ex_reg all 0, stall=0 immediately, x5 reads 0 afterwards.
//  - Writeback/bypass: wb x3=0xDEADBEEF while decoding ADD x1,x3,x3 (0x003180B3)
//    -> next cycle rs1_val=rs2_val=0xDEADBEEF, rd=1, valid=1.
//  - x0: wb_en=1, wb_rd=0, wb_data=0x55; then decode ADDI x2,x0,5 -> rs1_val=0, imm=5.
//  - Immediates:
//    - BEQ with offset -4 (0xFE000EE3) -> imm=0xFFFFFFFC.
//    - JAL with offset +2048 -> imm=0x00000800.
//    - LUI 0x12345 -> imm=0x12345000.
//  - Load-use: LW x5,0(x1) then ADD x6,x5,x2 -> stall=1 for 1 cycle, one bubble in ID_EX, then ADD valid.
//    LW x0 followed by use of x0 -> no stall.
//  - Flush+stall same cycle: stall conditions met with flush=1 -> stall=0, id_ex_reg.valid=0 next edge.

Source files
------------

// File: rtl/decode_unit_pkg.sv
// Shared widths, opcodes and pipeline-register payloads for the RISCAT ID stage.
package decode_unit_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned PC_W   = 16;
   localparam int unsigned INST_W = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned OP_W   = 7;

   localparam logic [OP_W-1:0] OP_OPIMM  = 7'b0010011;
   localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OP_W-1:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] fetched_inst;
   } if_id_t;

   typedef struct packed {
      logic              valid;
      logic [PC_W-1:0]   pc;
      logic [XLEN-1:0]   rs1_val;
      logic [XLEN-1:0]   rs2_val;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [OP_W-1:0]   opcode;
      logic [2:0]        funct3;
      logic              funct7b5;
   } id_ex_t;

endpackage

// File: rtl/decode_unit_if.sv
// ID-stage bus: IF_ID in, writeback port, flush, and the ID_EX / stall outputs.
interface decode_unit_if;
   import decode_unit_pkg::*;

   if_id_t              if_id_reg;
   logic                flush;
   logic                wb_en;
   logic [REG_AW-1:0]   wb_rd;
   logic [XLEN-1:0]     wb_data;
   logic                stall;
   id_ex_t              id_ex_reg;

   modport master (
      output if_id_reg, flush, wb_en, wb_rd, wb_data,
      input  stall, id_ex_reg
   );

   modport slave (
      input  if_id_reg, flush, wb_en, wb_rd, wb_data,
      output stall, id_ex_reg
   );

endinterface

// File: rtl/decode_unit.sv
// RISCAT ID stage: register file with write-through bypass, RV32I immediate decode,
// load-use hazard detection and flush squashing into the ID_EX register.
module decode_unit
   import decode_unit_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   decode_unit_if.slave  bus
);

   logic [XLEN-1:0]   rf_q [NREGS];
   id_ex_t            id_ex_q;
   id_ex_t            id_ex_d;

   logic [INST_W-1:0] inst;
   logic [OP_W-1:0]   opcode;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic [REG_AW-1:0] rd;
   logic [XLEN-1:0]   imm_c;
   logic [XLEN-1:0]   rs1_val_c;
   logic [XLEN-1:0]   rs2_val_c;
   logic              rs1_used_c;
   logic              rs2_used_c;
   logic              bubble_c;
   logic              wb_write_c;
   logic              stall_c;

   assign inst       = bus.if_id_reg.fetched_inst;
   assign opcode     = inst[6:0];
   assign rd         = inst[11:7];
   assign rs1        = inst[19:15];
   assign rs2        = inst[24:20];
   assign bubble_c   = (inst == '0);
   assign wb_write_c = bus.wb_en && (bus.wb_rd != '0);

   // Register file; x0 is never written and is forced to zero on read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_write_c) begin
         rf_q[bus.wb_rd] <= bus.wb_data;
      end
   end

   // Operand read with same-cycle writeback forwarding
   always_comb begin
      rs1_val_c = '0;
      rs2_val_c = '0;
      if (rs1 != '0) begin
         rs1_val_c = (wb_write_c && (bus.wb_rd == rs1)) ? bus.wb_data : rf_q[rs1];
      end
      if (rs2 != '0) begin
         rs2_val_c = (wb_write_c && (bus.wb_rd == rs2)) ? bus.wb_data : rf_q[rs2];
      end
   end

   always_comb begin
      imm_c = '0;
      unique case (opcode)
         OP_OPIMM, OP_LOAD, OP_JALR:
            imm_c = {{20{inst[31]}}, inst[31:20]};
         OP_STORE:
            imm_c = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         OP_BRANCH:
            imm_c = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm_c = {inst[31:12], 12'b0};
         OP_JAL:
            imm_c = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:
            imm_c = '0;
      endcase
   end

   // Which source fields are real operands, for hazard detection only
   always_comb begin
      rs1_used_c = 1'b1;
      rs2_used_c = 1'b0;
      unique case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL:       rs1_used_c = 1'b0;
         OP_REG, OP_STORE, OP_BRANCH:    rs2_used_c = 1'b1;
         default: ;
      endcase
   end

   // Load-use: the load in EX cannot forward in time, so hold fetch one cycle
   always_comb begin
      stall_c = 1'b0;
      if (!bus.flush && !bubble_c && id_ex_q.valid &&
          (id_ex_q.opcode == OP_LOAD) && (id_ex_q.rd != '0)) begin
         stall_c = (rs1_used_c && (rs1 == id_ex_q.rd)) ||
                   (rs2_used_c && (rs2 == id_ex_q.rd));
      end
   end

   always_comb begin
      id_ex_d = '0;
      if (!bus.flush && !stall_c && !bubble_c) begin
         id_ex_d.valid    = 1'b1;
         id_ex_d.pc       = bus.if_id_reg.pc;
         id_ex_d.rs1_val  = rs1_val_c;
         id_ex_d.rs2_val  = rs2_val_c;
         id_ex_d.imm      = imm_c;
         id_ex_d.rs1      = rs1;
         id_ex_d.rs2      = rs2;
         id_ex_d.rd       = rd;
         id_ex_d.opcode   = opcode;
         id_ex_d.funct3   = inst[14:12];
         id_ex_d.funct7b5 = inst[30];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

   assign bus.id_ex_reg = id_ex_q;
   assign bus.stall     = stall_c;

endmodule

// File: tb/tb_decode_unit.sv
// Directed self-checking bench for the RISCAT ID stage.
module tb_decode_unit;
   import decode_unit_pkg::*;

   localparam logic [31:0] I_ADD_1_3_3  = 32'h003180B3;
   localparam logic [31:0] I_SUB_1_2_3  = 32'h403100B3;
   localparam logic [31:0] I_ADDI_2_0_5 = 32'h00500113;
   localparam logic [31:0] I_ADDI_6_1_5 = 32'h00508313;
   localparam logic [31:0] I_BEQ_M4     = 32'hFE000EE3;
   localparam logic [31:0] I_JAL_2048   = 32'h0010006F;
   localparam logic [31:0] I_LUI_12345  = 32'h123450B7;
   localparam logic [31:0] I_SW_M8      = 32'hFE20AC23;
   localparam logic [31:0] I_LW_5_1     = 32'h0000A283;
   localparam logic [31:0] I_LW_0_1     = 32'h0000A003;
   localparam logic [31:0] I_ADD_6_5_2  = 32'h00228333;
   localparam logic [31:0] I_ADD_6_0_2  = 32'h00200333;

   logic clk;
   logic reset_n;
   int   tests_run;
   int   tests_failed;

   decode_unit_if bus();

   decode_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] inst, input logic [15:0] pc);
      bus.if_id_reg.fetched_inst = inst;
      bus.if_id_reg.pc           = pc;
   endtask

   task automatic test_reset;
      reset_n       = 1'b0;
      bus.flush     = 1'b0;
      bus.wb_en     = 1'b0;
      bus.wb_rd     = '0;
      bus.wb_data   = '0;
      drive(32'h0, 16'h0);
      #2;
      tests_run++;
      if (bus.id_ex_reg !== '0) begin
         tests_failed++;
         $display("FAIL reset_id_ex: got %h want 0", bus.id_ex_reg);
      end
      tests_run++;
      if (bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_stall: got %b want 0", bus.stall);
      end
      tick;
      tick;
      reset_n = 1'b1;
   endtask

   task automatic test_writeback_bypass;
      drive(I_ADD_1_3_3, 16'h0100);
      bus.wb_en   = 1'b1;
      bus.wb_rd   = 5'd3;
      bus.wb_data = 32'hDEADBEEF;
      tick;
      bus.wb_en = 1'b0;
      tests_run++;
      if (bus.id_ex_reg.rs1_val !== 32'hDEADBEEF || bus.id_ex_reg.rs2_val !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL bypass_vals: got %h/%h want deadbeef", bus.id_ex_reg.rs1_val, bus.id_ex_reg.rs2_val);
      end
      tests_run++;
      if (bus.id_ex_reg.rd !== 5'd1 || bus.id_ex_reg.valid !== 1'b1 || bus.id_ex_reg.pc !== 16'h0100) begin
         tests_failed++;
         $display("FAIL bypass_fields: got rd=%0d valid=%b pc=%h want rd=1 valid=1 pc=0100",
                  bus.id_ex_reg.rd, bus.id_ex_reg.valid, bus.id_ex_reg.pc);
      end
      tick;
      tests_run++;
      if (bus.id_ex_reg.rs1_val !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL regfile_read: got %h want deadbeef", bus.id_ex_reg.rs1_val);
      end
   endtask

   task automatic test_x0;
      drive(32'h0, 16'h0);
      bus.wb_en   = 1'b1;
      bus.wb_rd   = 5'd0;
      bus.wb_data = 32'h55;
      tick;
      bus.wb_en = 1'b0;
      drive(I_ADDI_2_0_5, 16'h0104);
      tick;
      tests_run++;
      if (bus.id_ex_reg.rs1_val !== 32'h0 || bus.id_ex_reg.imm !== 32'h5 || bus.id_ex_reg.rd !== 5'd2) begin
         tests_failed++;
         $display("FAIL x0_read: got rs1_val=%h imm=%h rd=%0d want 0/5/2",
                  bus.id_ex_reg.rs1_val, bus.id_ex_reg.imm, bus.id_ex_reg.rd);
      end
   endtask

   task automatic test_immediates;
      logic [31:0] insts [6];
      logic [31:0] imms  [6];
      insts = '{I_BEQ_M4, I_JAL_2048, I_LUI_12345, I_SW_M8, I_ADDI_6_1_5, I_ADD_1_3_3};
      imms  = '{32'hFFFFFFFC, 32'h00000800, 32'h12345000, 32'hFFFFFFF8, 32'h00000005, 32'h0};
      for (int i = 0; i < 6; i++) begin
         drive(insts[i], 16'(16'h0200 + 4 * i));
         tick;
         tests_run++;
         if (bus.id_ex_reg.imm !== imms[i] || bus.id_ex_reg.opcode !== insts[i][6:0]) begin
            tests_failed++;
            $display("FAIL imm_%0d: got imm=%h op=%h want imm=%h op=%h",
                     i, bus.id_ex_reg.imm, bus.id_ex_reg.opcode, imms[i], insts[i][6:0]);
         end
      end
      drive(I_SUB_1_2_3, 16'h0300);
      tick;
      tests_run++;
      if (bus.id_ex_reg.funct7b5 !== 1'b1 || bus.id_ex_reg.rs1 !== 5'd2 || bus.id_ex_reg.rs2 !== 5'd3) begin
         tests_failed++;
         $display("FAIL sub_fields: got f7b5=%b rs1=%0d rs2=%0d want 1/2/3",
                  bus.id_ex_reg.funct7b5, bus.id_ex_reg.rs1, bus.id_ex_reg.rs2);
      end
   endtask

   task automatic test_bubble;
      drive(32'h0, 16'h0ABC);
      tick;
      tests_run++;
      if (bus.id_ex_reg !== '0) begin
         tests_failed++;
         $display("FAIL bubble: got %h want 0", bus.id_ex_reg);
      end
   endtask

   task automatic test_load_use;
      drive(I_LW_5_1, 16'h0400);
      tick;
      drive(I_ADD_6_5_2, 16'h0404);
      #1;
      tests_run++;
      if (bus.stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL load_use_stall: got %b want 1", bus.stall);
      end
      tick;
      tests_run++;
      if (bus.id_ex_reg.valid !== 1'b0 || bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_use_bubble: got valid=%b stall=%b want 0/0", bus.id_ex_reg.valid, bus.stall);
      end
      tick;
      tests_run++;
      if (bus.id_ex_reg.valid !== 1'b1 || bus.id_ex_reg.rd !== 5'd6 || bus.id_ex_reg.pc !== 16'h0404) begin
         tests_failed++;
         $display("FAIL load_use_resume: got valid=%b rd=%0d pc=%h want 1/6/0404",
                  bus.id_ex_reg.valid, bus.id_ex_reg.rd, bus.id_ex_reg.pc);
      end
   endtask

   task automatic test_no_hazard;
      drive(I_LW_0_1, 16'h0500);
      tick;
      drive(I_ADD_6_0_2, 16'h0504);
      #1;
      tests_run++;
      if (bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_x0_stall: got %b want 0", bus.stall);
      end
      // ADDI's imm field aliases rs2=x5 but rs2 is not an operand
      drive(I_LW_5_1, 16'h0508);
      tick;
      drive(I_ADDI_6_1_5, 16'h050C);
      #1;
      tests_run++;
      if (bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL rs2_unused_stall: got %b want 0", bus.stall);
      end
      tick;
      tests_run++;
      if (bus.id_ex_reg.valid !== 1'b1 || bus.id_ex_reg.pc !== 16'h050C) begin
         tests_failed++;
         $display("FAIL rs2_unused_issue: got valid=%b pc=%h want 1/050c", bus.id_ex_reg.valid, bus.id_ex_reg.pc);
      end
   endtask

   task automatic test_flush_stall;
      drive(I_LW_5_1, 16'h0600);
      tick;
      drive(I_ADD_6_5_2, 16'h0604);
      bus.flush = 1'b1;
      #1;
      tests_run++;
      if (bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_stall: got %b want 0", bus.stall);
      end
      tick;
      bus.flush = 1'b0;
      tests_run++;
      if (bus.id_ex_reg.valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_bubble: got valid=%b want 0", bus.id_ex_reg.valid);
      end
   endtask

   task automatic test_reset_mid;
      bus.wb_en   = 1'b1;
      bus.wb_rd   = 5'd5;
      bus.wb_data = 32'h00001234;
      drive(32'h0, 16'h0);
      tick;
      bus.wb_en = 1'b0;
      drive(I_ADD_6_5_2, 16'h0700);
      tick;
      tests_run++;
      if (bus.id_ex_reg.rs1_val !== 32'h00001234) begin
         tests_failed++;
         $display("FAIL pre_reset_x5: got %h want 00001234", bus.id_ex_reg.rs1_val);
      end
      drive(I_LW_5_1, 16'h0704);
      tick;
      drive(I_ADD_6_5_2, 16'h0708);
      #1;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if (bus.id_ex_reg !== '0 || bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: got id_ex=%h stall=%b want 0/0", bus.id_ex_reg, bus.stall);
      end
      #1;
      reset_n = 1'b1;
      tick;
      tests_run++;
      if (bus.id_ex_reg.rs1_val !== 32'h0 || bus.id_ex_reg.valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL post_reset_x5: got rs1_val=%h valid=%b want 0/1",
                  bus.id_ex_reg.rs1_val, bus.id_ex_reg.valid);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset;
      test_writeback_bypass;
      test_x0;
      test_immediates;
      test_bubble;
      test_load_use;
      test_no_hazard;
      test_flush_stall;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
